// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package sync_fifo_pkg;

  // Read-side behaviour: registered read (STD) or first-word-fall-through.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus of the programmable synchronous FIFO.
interface sync_fifo_prog_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
);

  logic             wren;
  logic [WIDTH-1:0] wrdata;
  logic             rden;
  logic [CNT_W-1:0] af_thresh;
  logic [CNT_W-1:0] ae_thresh;
  logic             clr_err;
  logic [WIDTH-1:0] rddata;
  logic             rdvalid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             almost_full;
  logic             empty;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  // Side that drives requests and consumes status (producer/consumer logic).
  modport master (
    output wren, wrdata, rden, af_thresh, ae_thresh, clr_err,
    input  rddata, rdvalid, count, full, almost_full, empty, almost_empty,
           overflow, underflow
  );

  // Side implemented by the FIFO itself.
  modport slave (
    input  wren, wrdata, rden, af_thresh, ae_thresh, clr_err,
    output rddata, rdvalid, count, full, almost_full, empty, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH simple dual-port register array: synchronous write,
// asynchronous read. Contents are intentionally not reset.
module sync_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Programmable single-clock FIFO: arbitrary depth, STD or FWFT read mode,
// live almost-full/almost-empty thresholds, occupancy count and sticky
// overflow/underflow flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter fifo_mode_e  MODE  = FIFO_STD
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_prog_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Binary pointer increment with wrap at DEPTH-1 (depth need not be 2^n).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write alongside an accepted read; an empty FIFO never bypasses.
  assign rd_ok = bus.rden && !empty;
  assign wr_ok = bus.wren && (!full || rd_ok);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
    if (rd_ok) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh error in the same cycle as clr_err keeps the flag set.
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wren && !wr_ok) begin
      overflow_d = 1'b1;
    end
    if (bus.rden && !rd_ok) begin
      underflow_d = 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (bus.wrdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= bus.af_thresh);
  assign bus.almost_empty = (count_q <= bus.ae_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] rddata_q, rddata_d;
    logic             rdvalid_q, rdvalid_d;

    // Capture the head word on an accepted read; otherwise hold it.
    always_comb begin
      rddata_d  = rddata_q;
      rdvalid_d = rd_ok;
      if (rd_ok) begin
        rddata_d = mem_rdata;
      end
    end

    // Registered read port with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        rddata_q  <= '0;
        rdvalid_q <= 1'b0;
      end else begin
        rddata_q  <= rddata_d;
        rdvalid_q <= rdvalid_d;
      end
    end

    assign bus.rddata  = rddata_q;
    assign bus.rdvalid = rdvalid_q;
  end else begin : g_fwft
    // Head word is presented directly; forced to zero while empty.
    assign bus.rddata  = empty ? '0 : mem_rdata;
    assign bus.rdvalid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench: one STD and one FWFT instance, DEPTH=5.
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sync_fifo_prog_if #(.WIDTH(8), .CNT_W(3)) if_s ();
  sync_fifo_prog_if #(.WIDTH(8), .CNT_W(3)) if_f ();

  sync_fifo_prog #(.DEPTH(5), .WIDTH(8), .MODE(FIFO_STD)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  sync_fifo_prog #(.DEPTH(5), .WIDTH(8), .MODE(FIFO_FWFT)) dut_f (
    .clk (clk),
    .rst (rst),
    .bus (if_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_ae [4];
  logic [7:0] exp_af [4];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if_s.wren = 0; if_s.wrdata = '0; if_s.rden = 0; if_s.clr_err = 0;
    if_s.af_thresh = 3'd4; if_s.ae_thresh = 3'd1;
    if_f.wren = 0; if_f.wrdata = '0; if_f.rden = 0; if_f.clr_err = 0;
    if_f.af_thresh = 3'd4; if_f.ae_thresh = 3'd1;

    // Reset state
    tick();
    tick();
    chk("rst_count", if_s.count, 0);
    chk("rst_empty", if_s.empty, 1);
    chk("rst_full", if_s.full, 0);
    chk("rst_ae", if_s.almost_empty, 1);
    chk("rst_af", if_s.almost_full, 0);
    chk("rst_ovf", if_s.overflow, 0);
    chk("rst_udf", if_s.underflow, 0);
    chk("rst_rdvalid", if_s.rdvalid, 0);
    chk("rst_rddata", if_s.rddata, 0);
    chk("rst_f_rdvalid", if_f.rdvalid, 0);
    chk("rst_f_rddata", if_f.rddata, 0);
    if_s.af_thresh = 3'd0;
    #1;
    chk("af_thresh0_live", if_s.almost_full, 1);
    if_s.af_thresh = 3'd4;
    #1;
    chk("af_thresh4_live", if_s.almost_full, 0);
    rst = 1'b0;

    // STD fill to full, then overflow
    for (int i = 1; i <= 5; i++) begin
      if_s.wren = 1; if_s.wrdata = 8'(i * 8'h11);
      tick();
    end
    chk("fill_count", if_s.count, 5);
    chk("fill_full", if_s.full, 1);
    chk("fill_af", if_s.almost_full, 1);
    chk("fill_ae", if_s.almost_empty, 0);
    chk("fill_ovf_clear", if_s.overflow, 0);
    if_s.wrdata = 8'h66;
    tick();
    if_s.wren = 0;
    chk("ovf_set", if_s.overflow, 1);
    chk("ovf_count", if_s.count, 5);

    // STD drain in order, one-cycle read latency
    for (int i = 1; i <= 5; i++) begin
      if_s.rden = 1;
      tick();
      chk("drain_data", if_s.rddata, 32'(i * 8'h11));
      chk("drain_valid", if_s.rdvalid, 1);
      chk("drain_count", if_s.count, 32'(5 - i));
    end
    if_s.rden = 0;
    tick();
    chk("idle_valid", if_s.rdvalid, 0);
    chk("idle_hold", if_s.rddata, 8'h55);
    chk("idle_empty", if_s.empty, 1);
    chk("ovf_sticky", if_s.overflow, 1);
    if_s.clr_err = 1;
    tick();
    if_s.clr_err = 0;
    chk("ovf_cleared", if_s.overflow, 0);

    // Underflow, clear, set-wins-over-clear
    if_s.rden = 1;
    tick();
    if_s.rden = 0;
    chk("udf_set", if_s.underflow, 1);
    chk("udf_rdvalid", if_s.rdvalid, 0);
    if_s.clr_err = 1;
    tick();
    chk("udf_cleared", if_s.underflow, 0);
    if_s.rden = 1;
    tick();
    if_s.rden = 0; if_s.clr_err = 0;
    chk("udf_set_wins", if_s.underflow, 1);

    // Read on empty with simultaneous write: write lands, read rejected
    if_s.wren = 1; if_s.rden = 1; if_s.wrdata = 8'h77; if_s.clr_err = 1;
    tick();
    if_s.wren = 0; if_s.rden = 0; if_s.clr_err = 0;
    chk("rw_empty_count", if_s.count, 1);
    chk("rw_empty_udf", if_s.underflow, 1);
    chk("rw_empty_valid", if_s.rdvalid, 0);
    if_s.rden = 1; if_s.clr_err = 1;
    tick();
    if_s.rden = 0; if_s.clr_err = 0;
    chk("rw_empty_data", if_s.rddata, 8'h77);
    chk("rw_empty_udf_clr", if_s.underflow, 0);

    // FWFT: write at edge N visible in cycle N+1, pop empties
    chk("fwft_pre_valid", if_f.rdvalid, 0);
    if_f.wren = 1; if_f.wrdata = 8'hA5;
    tick();
    if_f.wren = 0;
    chk("fwft_valid", if_f.rdvalid, 1);
    chk("fwft_data", if_f.rddata, 8'hA5);
    chk("fwft_not_empty", if_f.empty, 0);
    if_f.rden = 1;
    tick();
    if_f.rden = 0;
    chk("fwft_pop_empty", if_f.empty, 1);
    chk("fwft_pop_valid", if_f.rdvalid, 0);
    chk("fwft_pop_data", if_f.rddata, 0);

    // STD full with simultaneous write+read for 10 cycles across wrap
    for (int i = 1; i <= 5; i++) begin
      if_s.wren = 1; if_s.wrdata = 8'(i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      if_s.wren = 1; if_s.rden = 1; if_s.wrdata = 8'(6 + k);
      tick();
      chk("stream_data", if_s.rddata, 32'(k + 1));
      chk("stream_count", if_s.count, 5);
    end
    if_s.wren = 0;
    chk("stream_ovf", if_s.overflow, 0);
    for (int i = 11; i <= 15; i++) begin
      tick();
      chk("stream_tail", if_s.rddata, 32'(i));
    end
    if_s.rden = 0;
    tick();
    chk("stream_empty", if_s.empty, 1);

    // Threshold boundaries on FWFT: af=3, ae=1
    if_f.af_thresh = 3'd3; if_f.ae_thresh = 3'd1;
    exp_ae = '{8'd1, 8'd0, 8'd0, 8'd0};
    exp_af = '{8'd0, 8'd0, 8'd1, 8'd1};
    #1;
    chk("thr0_ae", if_f.almost_empty, 1);
    chk("thr0_af", if_f.almost_full, 0);
    for (int c = 1; c <= 4; c++) begin
      if_f.wren = 1; if_f.wrdata = 8'(8'hC0 + c);
      tick();
      chk("thr_count", if_f.count, 32'(c));
      chk("thr_ae", if_f.almost_empty, 32'(exp_ae[c-1]));
      chk("thr_af", if_f.almost_full, 32'(exp_af[c-1]));
    end
    if_f.wren = 0;
    chk("thr_head", if_f.rddata, 8'hC1);

    // Mid-stream reset, overriding a concurrent write
    for (int i = 1; i <= 3; i++) begin
      if_s.wren = 1; if_s.wrdata = 8'(8'h30 + i);
      tick();
    end
    chk("pre_rst_count", if_s.count, 3);
    if_s.wrdata = 8'hEE;
    rst = 1;
    tick();
    rst = 0; if_s.wren = 0;
    chk("mid_rst_count", if_s.count, 0);
    chk("mid_rst_empty", if_s.empty, 1);
    chk("mid_rst_valid", if_s.rdvalid, 0);
    chk("mid_rst_f_count", if_f.count, 0);
    chk("mid_rst_f_valid", if_f.rdvalid, 0);
    if_s.wren = 1; if_s.wrdata = 8'h99;
    if_f.wren = 1; if_f.wrdata = 8'h5A;
    tick();
    if_s.wren = 0; if_f.wren = 0;
    chk("post_rst_f_data", if_f.rddata, 8'h5A);
    chk("post_rst_f_count", if_f.count, 1);
    if_s.rden = 1;
    tick();
    if_s.rden = 0;
    chk("post_rst_data", if_s.rddata, 8'h99);
    chk("post_rst_valid", if_s.rdvalid, 1);
    chk("post_rst_count", if_s.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised single-clock FIFO, successor to the fixed-threshold sync FIFO. Adds any depth ≥ 2 (not just powers of two), a selectable standard or first-word-fall-through (FWFT) read mode, run-time programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Sits between producer and consumer logic in one clock domain wherever buffering with back-pressure thresholds is needed.

## Interface
- `DEPTH`, 16, number of entries; any integer ≥ 2.
- `WIDTH`, 8, data word width in bits; ≥ 1.
- `MODE`, `FIFO_STD`, read mode (`fifo_mode_e`): `FIFO_STD` or `FIFO_FWFT`.
- `CNT_W` (localparam) = `$clog2(DEPTH+1)`; `PTR_W` (localparam) = `max(1, $clog2(DEPTH))`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wren` in 1: write request.
- `wrdata` in WIDTH: write data.
- `rden` in 1: read request (pop).
- `af_thresh` in CNT_W: almost-full threshold.
- `ae_thresh` in CNT_W: almost-empty threshold.
- `clr_err` in 1: clears the sticky error flags.
- `rddata` out WIDTH: read data.
- `rdvalid` out 1: `rddata` holds a valid word.
- `count` out CNT_W: current occupancy, 0..DEPTH.
- `full`, `almost_full`, `empty`, `almost_empty` out 1: status flags.
- `overflow`, `underflow` out 1: sticky error flags.

## Operation
- Write accepted (`wr_ok`) = `wren && (!full || rd_ok)`. Stores `wrdata` at `wr_ptr`; `wr_ptr` advances, wrapping from DEPTH-1 to 0.
- Read accepted (`rd_ok`) = `rden && !empty`. `rd_ptr` advances with the same wrap rule.
- `count` next = count + wr_ok − rd_ok. Pointers are binary 0..DEPTH-1, and full/empty come from `count` alone, with no extra pointer MSB.
- Flags are combinational from registered `count`:
  - `full` = (count == DEPTH); `empty` = (count == 0).
  - `almost_full` = (count ≥ af_thresh); `almost_empty` = (count ≤ ae_thresh).
- Thresholds are sampled live with no registering. A threshold change affects the flags in the same cycle.
- `wren && !wr_ok` sets `overflow`, and the word is dropped. `rden && !rd_ok` sets `underflow`, and no state changes.
- `clr_err` clears both flags next edge. If a new error occurs in the same cycle, set wins.
- Write while full with a simultaneous accepted read succeeds, and `count` stays at DEPTH.
- Read while empty with a simultaneous write is rejected (underflow) in both modes.
- STD mode: on `rd_ok`, `rddata` is registered from `mem[rd_ptr]`, and `rdvalid` pulses high for the following cycle. Otherwise `rdvalid`=0 and `rddata` holds its last value.
- FWFT mode: `rdvalid` = !empty. `rddata` = `mem[rd_ptr]` when !empty, else 0. `rden` pops the presented word.
- Storage is not reset.

## Timing
- Reset values: count 0, pointers 0, empty 1, full 0, almost_empty 1, overflow 0, underflow 0, rdvalid 0, rddata 0. `almost_full` is 1 only if af_thresh == 0.
- Write-to-visible latency is 1 cycle in both modes. A word written at edge N gives empty=0 and, in FWFT, valid `rddata` during cycle N+1.
- STD read latency is 1: `rden` accepted at edge N puts data and `rdvalid` in cycle N+1.
- Throughput is one write plus one read per cycle, sustained.
- `rst` asserted mid-operation discards all contents at that edge. It overrides wren/rden/clr_err in the same cycle.

## Structure
- `sync_fifo_pkg` holds `typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e`.
- Sub-module `sync_fifo_mem`: DEPTH×WIDTH simple dual-port register array with synchronous write and asynchronous read.
- Top level holds the pointers, count, flags, error logic and STD output register.

## Test plan
- Reset, then DEPTH=5 STD, write 0x11..0x55 → count 5, full=1. A 6th write sets overflow=1 and count stays 5.
- Empty FIFO, assert `rden` alone → underflow=1, rdvalid stays 0. Then `clr_err` → underflow=0 next cycle.
- DEPTH=5 FWFT, write 0xA5 at edge N → rdvalid=1 and rddata=0xA5 in cycle N+1. `rden` → empty=1 next cycle.
- Full FIFO with simultaneous wren+rden for 10 cycles → count stays 5, order preserved across pointer wrap, overflow stays 0.
- af_thresh=3, ae_thresh=1, fill 0→4 → almost_empty high at count 0–1, almost_full asserts exactly at count 3.
- Assert `rst` with count=3 mid-stream → next cycle count 0, empty=1, rdvalid=0, and a following write/read returns only new data.
